// File: rtl/bus_mem_responder_pkg.sv
// bus_mem_responder_pkg: FSM state encoding and error data word shared by the responder.
package bus_mem_responder_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;
endpackage

// File: rtl/bus_mem_responder_sram.sv
// bus_sram_1p: single-port synchronous RAM, 1-cycle registered read, block-RAM inferable.
module bus_sram_1p #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [2**AW];
  always_ff @(posedge clk)
    if (en) begin
      if (we) mem[addr] <= wdata;
      else rdata <= mem[addr];
    end
endmodule

// File: rtl/bus_mem_responder.sv
// bus_mem_responder: wait-state memory responder with ready handshake and sticky bus error.
// Define MEM_RANGE_CHECK_EN to enable range checking; otherwise the region aliases.
module bus_mem_responder
  import bus_mem_responder_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 12,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h20000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] d,
  input  logic        we,
  input  logic        rd,
  output logic [31:0] spo,
  output logic        ready,
  output logic        bus_err
);
  state_t state, nxt;
  logic [3:0] cnt;
  logic is_rd, oor, in_range, strobe, accept;
  logic [31:0] spo_q, ram_q, rdata;
  logic unused_bits;
  assign strobe = we | rd;
  assign accept = state == IDLE && strobe;
  assign unused_bits = ^{a[31:ADDR_WIDTH+2], a[1:0]};
`ifdef MEM_RANGE_CHECK_EN
  logic [31:0] off;
  assign off = a - BASE_ADDR;
  assign in_range = a >= BASE_ADDR && (off >> (ADDR_WIDTH + 2)) == 32'd0;
  always_ff @(posedge clk or posedge rst)
    if (rst) bus_err <= 1'b0;
    else if (accept && !in_range) bus_err <= 1'b1;
`else
  assign in_range = 1'b1;
  assign bus_err = 1'b0;
`endif
  // Out-of-range accesses never touch the RAM; reads get ERR_WORD instead.
  bus_sram_1p #(.AW(ADDR_WIDTH)) u_ram (
    .clk(clk),
    .en(accept && in_range),
    .we(we),
    .addr(a[ADDR_WIDTH+1:2]),
    .wdata(d),
    .rdata(ram_q)
  );
  assign rdata = oor ? ERR_WORD : ram_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      is_rd <= 1'b0;
      oor <= 1'b0;
      spo_q <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        cnt <= 4'(WAIT_CYCLES);
        is_rd <= !we;
        oor <= !in_range;
      end else if (state == BUSY) cnt <= cnt - 4'd1;
      if (state == DONE && is_rd) spo_q <= rdata;
    end
  always_comb begin
    nxt = IDLE;
    if (state == IDLE) nxt = strobe ? (WAIT_CYCLES == 0 ? DONE : BUSY) : IDLE;
    else if (state == BUSY) nxt = cnt == 4'd1 ? DONE : BUSY;
  end
  // RAM output stays stable after cycle 0 because strobes are ignored until IDLE.
  assign ready = (state == IDLE && !strobe) || state == DONE;
  assign spo = (state == DONE && is_rd) ? rdata : spo_q;
endmodule
